// File: rtl/osc_clk_supervisor.sv
// Oscillator clock supervisor: counts MON_CLK edges over fixed CLK windows, flags good/fail, sequences fabric reset.
// Optional MIN_COUNT/MAX_COUNT extreme tracking is built when OSC_CLK_SUPERVISOR_MINMAX_EN is defined.
//
// state   | meaning
// IDLE    | disabled; flags cleared, EDGE_COUNT holds
// STARTUP | settle delay after enable, before the first window
// MEASURE | counting synchronized MON_CLK rising edges
// EVAL    | one cycle; window count judged against the tolerance band
// FAULT   | FAIL_LIMIT consecutive failing windows; waits for FORCE_RECHECK
module osc_clk_supervisor #(
  parameter int STARTUP_CYCLES = 1024,
  parameter int WINDOW_CYCLES  = 5000,
  parameter int EXP_EDGES      = 100,
  parameter int TOL_EDGES      = 5,
  parameter int FAIL_LIMIT     = 3,
  parameter int RST_HOLD       = 16
) (
  input  logic        CLK,
  input  logic        RESET_N,
  input  logic        MON_CLK,
  input  logic        ENABLE,
  input  logic        FORCE_RECHECK,
  output logic        CLK_OK,
  output logic        CLK_FAIL,
  output logic        FABRIC_RESET_N,
  output logic        MEAS_VALID,
  output logic [15:0] EDGE_COUNT,
`ifdef OSC_CLK_SUPERVISOR_MINMAX_EN
  output logic [15:0] MIN_COUNT,
  output logic [15:0] MAX_COUNT,
`endif
  output logic [2:0]  STATE
);

  localparam int ST_W   = (STARTUP_CYCLES > 1) ? $clog2(STARTUP_CYCLES) : 1;
  localparam int WIN_W  = (WINDOW_CYCLES > 1) ? $clog2(WINDOW_CYCLES) : 1;
  localparam int HOLD_W = (RST_HOLD > 1) ? $clog2(RST_HOLD) : 1;
  localparam int FAIL_W = $clog2(FAIL_LIMIT + 1);
  localparam int LO_I   = (EXP_EDGES > TOL_EDGES) ? (EXP_EDGES - TOL_EDGES) : 0;
  localparam int HI_I   = ((EXP_EDGES + TOL_EDGES) > 65535) ? 65535 : (EXP_EDGES + TOL_EDGES);

  localparam logic [15:0]       LO_BOUND  = 16'(LO_I);
  localparam logic [15:0]       HI_BOUND  = 16'(HI_I);
  localparam logic [ST_W-1:0]   ST_LOAD   = ST_W'(STARTUP_CYCLES - 1);
  localparam logic [WIN_W-1:0]  WIN_LOAD  = WIN_W'(WINDOW_CYCLES - 1);
  localparam logic [HOLD_W-1:0] HOLD_LOAD = HOLD_W'(RST_HOLD - 1);
  localparam logic [FAIL_W-1:0] FAIL_MAX  = FAIL_W'(FAIL_LIMIT);

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_STARTUP = 3'd1,
    S_MEASURE = 3'd2,
    S_EVAL    = 3'd3,
    S_FAULT   = 3'd4
  } state_t;

  state_t state, next_state;

  logic              mon_s1, mon_s2, mon_s3, edge_q;
  logic [15:0]       win_cnt;
  logic [ST_W-1:0]   startup_tmr;
  logic [WIN_W-1:0]  win_tmr;
  logic [HOLD_W-1:0] hold_tmr;
  logic              hold_run;
  logic [FAIL_W-1:0] fail_cnt;
  logic [FAIL_W-1:0] fail_cnt_inc;
  logic              win_pass;
  logic              eval_now;

  assign fail_cnt_inc = fail_cnt + FAIL_W'(1);
  assign win_pass     = (win_cnt >= LO_BOUND) && (win_cnt <= HI_BOUND);

  // Two-flop synchronizer, then a registered rising-edge detect: an edge reaches the counter 3 cycles after sampling.
  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N) begin
      mon_s1 <= 1'b0;
      mon_s2 <= 1'b0;
      mon_s3 <= 1'b0;
      edge_q <= 1'b0;
    end else begin
      mon_s1 <= MON_CLK;
      mon_s2 <= mon_s1;
      mon_s3 <= mon_s2;
      edge_q <= mon_s2 & ~mon_s3;
    end
  end

  // Counter only runs in MEASURE; it is read during EVAL and cleared everywhere else.
  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N) begin
      win_cnt <= '0;
    end else if (state == S_MEASURE) begin
      if (edge_q && (win_cnt != 16'hFFFF)) win_cnt <= win_cnt + 16'd1;
    end else begin
      win_cnt <= '0;
    end
  end

  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N) begin
      startup_tmr <= '0;
      win_tmr     <= '0;
    end else begin
      if (state != S_STARTUP)       startup_tmr <= ST_LOAD;
      else if (startup_tmr != '0)   startup_tmr <= startup_tmr - ST_W'(1);
      if (state != S_MEASURE)       win_tmr <= WIN_LOAD;
      else if (win_tmr != '0)       win_tmr <= win_tmr - WIN_W'(1);
    end
  end

  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N) state <= S_IDLE;
    else          state <= next_state;
  end

  always_comb begin
    next_state = state;
    if (!ENABLE) begin
      next_state = S_IDLE;
    end else begin
      case (state)
        S_IDLE:    next_state = S_STARTUP;
        S_STARTUP: if (startup_tmr == '0) next_state = S_MEASURE;
        S_MEASURE: if (win_tmr == '0) next_state = S_EVAL;
        S_EVAL:    next_state = (!win_pass && (fail_cnt_inc == FAIL_MAX)) ? S_FAULT : S_MEASURE;
        S_FAULT:   if (FORCE_RECHECK) next_state = S_STARTUP;
        default:   next_state = S_IDLE;
      endcase
    end
  end

  always_comb begin
    STATE    = state;
    CLK_FAIL = (state == S_FAULT);
    eval_now = (state == S_EVAL);
  end

  // A late assignment in the ENABLE/EVAL/FAULT branches overrides the hold countdown in the same cycle.
  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N) begin
      CLK_OK         <= 1'b0;
      FABRIC_RESET_N <= 1'b0;
      MEAS_VALID     <= 1'b0;
      EDGE_COUNT     <= '0;
      fail_cnt       <= '0;
      hold_tmr       <= '0;
      hold_run       <= 1'b0;
    end else begin
      MEAS_VALID <= 1'b0;
      if (hold_run) begin
        if (hold_tmr == '0) begin
          FABRIC_RESET_N <= 1'b1;
          hold_run       <= 1'b0;
        end else begin
          hold_tmr <= hold_tmr - HOLD_W'(1);
        end
      end
      if (!ENABLE) begin
        CLK_OK         <= 1'b0;
        FABRIC_RESET_N <= 1'b0;
        fail_cnt       <= '0;
        hold_run       <= 1'b0;
      end else if (eval_now) begin
        MEAS_VALID <= 1'b1;
        EDGE_COUNT <= win_cnt;
        if (win_pass) begin
          fail_cnt <= '0;
          CLK_OK   <= 1'b1;
          if (!CLK_OK) begin
            hold_tmr <= HOLD_LOAD;
            hold_run <= 1'b1;
          end
        end else begin
          CLK_OK         <= 1'b0;
          FABRIC_RESET_N <= 1'b0;
          hold_run       <= 1'b0;
          fail_cnt       <= fail_cnt_inc;
        end
      end else if (state == S_FAULT) begin
        CLK_OK         <= 1'b0;
        FABRIC_RESET_N <= 1'b0;
        hold_run       <= 1'b0;
        if (FORCE_RECHECK) fail_cnt <= '0;
      end
    end
  end

`ifdef OSC_CLK_SUPERVISOR_MINMAX_EN
  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N) begin
      MIN_COUNT <= 16'hFFFF;
      MAX_COUNT <= '0;
    end else if ((state == S_IDLE) && (next_state != S_IDLE)) begin
      MIN_COUNT <= 16'hFFFF;
      MAX_COUNT <= '0;
    end else if (ENABLE && eval_now) begin
      if (win_cnt < MIN_COUNT) MIN_COUNT <= win_cnt;
      if (win_cnt > MAX_COUNT) MAX_COUNT <= win_cnt;
    end
  end
`endif

endmodule
